instr_loader: RTL and testbench



---
 rtl/instr_loader_pkg.sv | 17 +
 rtl/loader_word_packer.sv | 34 +++
 rtl/instr_loader.sv | 120 ++++++++++++
 tb/tb_instr_loader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and widths for the boot-time instruction loader.
package instr_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_e;

endpackage

// File: rtl/loader_word_packer.sv
// Packs a big-endian byte stream into 32-bit words; first byte lands in bits 31:24.
module loader_word_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]              count_q;
  // Only the three older bytes need storage; the fourth is the live input.
  logic [WORD_W-BYTE_W-1:0] shift_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
      shift_q <= '0;
    end else if (clear) begin
      count_q <= 2'd0;
      shift_q <= '0;
    end else if (byte_valid) begin
      count_q <= count_q + 2'd1;
      shift_q <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_in};
    end
  end

  assign word_valid = byte_valid && (count_q == 2'd3);
  assign word       = {shift_q, byte_in};

endmodule

// File: rtl/instr_loader.sv
// Boot loader: length header, packed instruction words, XOR checksum; releases core on success.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [WORD_W-1:0] imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output state_e            dbg_state
);

  localparam logic [31:0] DEPTH_LIM = DEPTH_WORDS;

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready is
  // registered from the state and never depends on in_valid.
  state_e             state_q, state_d;
  logic               in_ready_q, imem_we_q, core_hold_q, done_q, error_q;
  logic [WORD_W-1:0]  imem_waddr_q, imem_wdata_q;
  logic [BYTE_W-1:0]  len_hi_q, csum_q;
  logic [LEN_W-1:0]   len_q, idx_q, n_full;
  logic               accept, clear_ld, data_byte, word_valid;
  logic [WORD_W-1:0]  word;

  assign accept    = in_valid && in_ready_q;
  assign data_byte = accept && (state_q == DATA);
  assign n_full    = {len_hi_q, in_data};

  loader_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_ld),
    .byte_valid (data_byte),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d  = state_q;
    clear_ld = 1'b0;
    case (state_q)
      LEN_HI: if (accept) state_d = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if ({16'd0, n_full} > DEPTH_LIM) state_d = ERROR;
          else if (n_full == '0)           state_d = CSUM;
          else                             state_d = DATA;
        end
      end
      DATA: if (word_valid && (idx_q == len_q - LEN_W'(1))) state_d = CSUM;
      CSUM: if (accept) state_d = (in_data == csum_q) ? DONE : ERROR;
      DONE, ERROR: begin
        if (start) begin
          state_d  = LEN_HI;
          clear_ld = 1'b1;
        end
      end
      default: state_d = LEN_HI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LEN_HI;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      len_hi_q     <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == LEN_HI) || (state_d == LEN_LO) ||
                     (state_d == DATA)   || (state_d == CSUM);
      core_hold_q <= (state_d != DONE);
      done_q      <= (state_d == DONE);
      error_q     <= (state_d == ERROR);
      imem_we_q   <= word_valid;

      if (accept && state_q == LEN_HI) len_hi_q <= in_data;
      if (accept && state_q == LEN_LO) len_q    <= n_full;

      if (clear_ld)       csum_q <= '0;
      else if (data_byte) csum_q <= csum_q ^ in_data;

      if (clear_ld) begin
        idx_q <= '0;
      end else if (word_valid) begin
        imem_waddr_q <= {14'd0, idx_q, 2'b00};
        imem_wdata_q <= word;
        idx_q        <= idx_q + LEN_W'(1);
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: expected writes queued by stimulus, checked by a monitor.
module tb_instr_loader;
  import instr_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        start = 1'b0;
  logic        in_ready, imem_we, core_hold, done, error;
  logic [31:0] imem_waddr, imem_wdata;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  instr_loader #(.DEPTH_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the next queued {addr, data}
  always @(negedge clk) begin
    if (reset && imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %h @ %h, required no write", imem_wdata, imem_waddr);
      end else begin
        check("imem_write", {imem_waddr, imem_wdata}, exp_q.pop_front());
      end
    end
  end

  // Drivers: all input changes happen on the falling edge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: got 0, required 1 within 50 cycles");
    end
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] bq[$], input bit gaps);
    int gap_pos = 1;
    for (int i = 0; i < bq.size(); i++) begin
      if (i >= 2 && ((i - 2) % 4) == 0) gap_pos = $urandom_range(1, 3);
      if (gaps && i >= 2 && i < bq.size() - 1 && ((i - 2) % 4) == gap_pos)
        repeat (3) @(negedge clk);
      send_byte(bq[i]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_stream1_writes();
    exp_q.push_back({32'h0000_0000, 32'h2001_0005});
    exp_q.push_back({32'h0000_0004, 32'h0022_1820});
  endtask

  task automatic check_status(input string name, input logic hold, input logic dn,
                              input logic er, input logic rdy);
    check(name, {60'd0, core_hold, done, error, in_ready}, {60'd0, hold, dn, er, rdy});
  endtask

  logic [7:0] s_good[$], s_bad[$], s_big[$], s_zero[$], s_part[$];

  initial begin
    s_good = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20, 8'h3E};
    s_bad  = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20, 8'h3F};
    s_big  = '{8'h01, 8'h01};
    s_zero = '{8'h00, 8'h00, 8'h00};
    s_part = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22};

    // Reset values
    repeat (2) @(negedge clk);
    check_status("reset_status", 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_imem", {31'd0, imem_we, imem_waddr}, 64'd0);
    check("reset_wdata", {32'd0, imem_wdata}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Good image
    push_stream1_writes();
    send_stream(s_good, 1'b0);
    check_status("good_done", 1'b0, 1'b1, 1'b0, 1'b0);
    check("good_state", {61'd0, dbg_state}, {61'd0, DONE});

    // Bad checksum
    pulse_start();
    check_status("restart_hold", 1'b1, 1'b0, 1'b0, 1'b1);
    push_stream1_writes();
    send_stream(s_bad, 1'b0);
    check_status("bad_csum", 1'b1, 1'b0, 1'b1, 1'b0);

    // Oversized length
    pulse_start();
    send_stream(s_big, 1'b0);
    check_status("len_too_big", 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // Good image with input gaps
    pulse_start();
    push_stream1_writes();
    send_stream(s_good, 1'b1);
    check_status("gap_done", 1'b0, 1'b1, 1'b0, 1'b0);

    // Zero-length image
    pulse_start();
    check_status("zero_reload_hold", 1'b1, 1'b0, 1'b0, 1'b1);
    send_byte(s_zero[0]);
    send_byte(s_zero[1]);
    check_status("zero_in_csum", 1'b1, 1'b0, 1'b0, 1'b1);
    send_byte(s_zero[2]);
    check_status("zero_done", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of word 1
    pulse_start();
    exp_q.push_back({32'h0000_0000, 32'h2001_0005});
    send_stream(s_part, 1'b0);
    reset = 1'b0;
    #1;
    check_status("midreset_status", 1'b1, 1'b0, 1'b0, 1'b0);
    check("midreset_imem", {31'd0, imem_we, imem_waddr}, 64'd0);
    check("midreset_wdata", {32'd0, imem_wdata}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_stream1_writes();
    send_stream(s_good, 1'b0);
    check_status("after_reset_done", 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("writes_outstanding", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
